// File: rtl/hazard_pkg.sv
// Shared types and control-word constants for the pipeline hazard controller.
// Contents: FSM state enum, packed pipeline control word, and one constant
// control word per priority case (mem stall > redirect > flush > load-use > run).
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic memwb_clr;
  } pipe_ctrl_t;

  // Control words in priority order, highest first; CTRL_OFF applies during rst.
  localparam pipe_ctrl_t CTRL_MEM_STALL = 7'b000_000_1;
  localparam pipe_ctrl_t CTRL_REDIRECT  = 7'b111_111_0;
  localparam pipe_ctrl_t CTRL_FLUSH     = 7'b111_101_0;
  localparam pipe_ctrl_t CTRL_LOAD_USE  = 7'b000_111_0;
  localparam pipe_ctrl_t CTRL_RUN       = 7'b110_101_0;
  localparam pipe_ctrl_t CTRL_OFF       = 7'b000_000_0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and the controller.
// master: datapath side (drives hazard inputs, receives stage controls/status).
// slave : controller side (inputs: register indices, load/redirect/stall
//         flags; outputs: stage en/clr, in_flush, mem_timeout, perf counters).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_redirect;
  logic             mem_stall_req;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_clr;
  logic             idex_en;
  logic             idex_clr;
  logic             exmem_en;
  logic             memwb_clr;
  logic             in_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_stall_req,
    input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_clr,
           in_flush, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_stall_req,
    output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_clr,
           in_flush, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, rst, inc (count enable), count (current value, sticks at all-ones).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: hold at all-ones once saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// EX redirects with FETCH_LAT extra IF/ID flush cycles, data-memory wait
// states, a sticky memory-timeout flag and saturating stall/flush counters.
// Ports: clk, rst (sync, active-high), hz (slave modport carrying all hazard
// inputs and the combinational stage controls, status and counters).
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned MAX_WAIT  = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [3:0]        FLUSH_LEN = 4'(FETCH_LAT);
  localparam bit                HAS_FLUSH = (FETCH_LAT != 0);

  hz_state_t         state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  pipe_ctrl_t        ctrl_c;
  logic              load_use_c;
  logic              flush_inc_c;

  // Load in EX whose destination is read by the instruction in ID
  assign load_use_c = (state_q == RUN) && hz.ex_mem_read && (hz.ex_rd != REG_W'(0)) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Priority resolution and next state; a redirect under mem stall waits for EX to unfreeze
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ctrl_c      = CTRL_RUN;
    flush_inc_c = 1'b0;
    if (rst) begin
      ctrl_c = CTRL_OFF;
    end else if (hz.mem_stall_req) begin
      ctrl_c = CTRL_MEM_STALL;
    end else if (hz.ex_redirect) begin
      ctrl_c      = CTRL_REDIRECT;
      flush_inc_c = 1'b1;
      if (HAS_FLUSH) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_LEN;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == FLUSH) begin
      ctrl_c      = CTRL_FLUSH;
      flush_cnt_d = flush_cnt_q - 4'd1;
      if (flush_cnt_q == 4'd1) state_d = RUN;
    end else if (load_use_c) begin
      ctrl_c = CTRL_LOAD_USE;
    end
  end

  // Consecutive mem-stall cycle counter and sticky timeout
  always_comb begin
    wait_cnt_d = '0;
    if (hz.mem_stall_req) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl_c.pc_en),
    .count (hz.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc_c),
    .count (hz.flush_events)
  );

  assign hz.pc_en       = ctrl_c.pc_en;
  assign hz.ifid_en     = ctrl_c.ifid_en;
  assign hz.ifid_clr    = ctrl_c.ifid_clr;
  assign hz.idex_en     = ctrl_c.idex_en;
  assign hz.idex_clr    = ctrl_c.idex_clr;
  assign hz.exmem_en    = ctrl_c.exmem_en;
  assign hz.memwb_clr   = ctrl_c.memwb_clr;
  assign hz.in_flush    = (state_q == FLUSH);
  assign hz.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-by-cycle vector table on an
// instance with FETCH_LAT=2/MAX_WAIT=4, then hand sequences on a FETCH_LAT=3
// instance for reset mid-flush and a full three-cycle flush window.
module tb_pipeline_hazard_ctrl;

  // Expected control words {pc_en,ifid_en,ifid_clr,idex_en,idex_clr,exmem_en,memwb_clr}
  localparam logic [6:0] E_OFF = 7'b0000000;
  localparam logic [6:0] E_RUN = 7'b1101010;
  localparam logic [6:0] E_MEM = 7'b0000001;
  localparam logic [6:0] E_RDR = 7'b1111110;
  localparam logic [6:0] E_FLS = 7'b1111010;
  localparam logic [6:0] E_LU  = 7'b0001110;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        mr;
    logic [4:0]  rd;
    logic        rdr;
    logic        st;
    logic [6:0]  ctrl;
    logic        inf;
    logic        to;
    int unsigned sc;
    int unsigned fe;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) if0 ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) if1 ();

  pipeline_hazard_ctrl #(.REG_W(5), .FETCH_LAT(2), .MAX_WAIT(4), .CNT_W(32)) u0 (
    .clk (clk), .rst (rst), .hz (if0.slave)
  );
  pipeline_hazard_ctrl #(.REG_W(5), .FETCH_LAT(3), .MAX_WAIT(4), .CNT_W(32)) u1 (
    .clk (clk), .rst (rst), .hz (if1.slave)
  );

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic mr, logic [4:0] rd, logic rdr, logic st, logic [6:0] c,
                              logic inf, logic to, int unsigned sc, int unsigned fe);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
    v.rdr = rdr; v.st = st; v.ctrl = c; v.inf = inf; v.to = to; v.sc = sc; v.fe = fe;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    if0.id_rs1 = v.rs1; if0.id_rs2 = v.rs2; if0.id_use_rs1 = v.u1; if0.id_use_rs2 = v.u2;
    if0.ex_mem_read = v.mr; if0.ex_rd = v.rd; if0.ex_redirect = v.rdr; if0.mem_stall_req = v.st;
    if1.id_rs1 = v.rs1; if1.id_rs2 = v.rs2; if1.id_use_rs1 = v.u1; if1.id_use_rs2 = v.u2;
    if1.ex_mem_read = v.mr; if1.ex_rd = v.rd; if1.ex_redirect = v.rdr; if1.mem_stall_req = v.st;
  endtask

  // Apply one cycle of inputs at the falling edge, sample outputs shortly after
  task automatic step(input logic r, input logic rdr, input logic st);
    @(negedge clk);
    drive(mk(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, rdr, st, E_OFF, 1'b0, 1'b0, 0, 0));
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [6:0] ctrl0();
    return {if0.pc_en, if0.ifid_en, if0.ifid_clr, if0.idex_en, if0.idex_clr, if0.exmem_en, if0.memwb_clr};
  endfunction

  function automatic logic [6:0] ctrl1();
    return {if1.pc_en, if1.ifid_en, if1.ifid_clr, if1.idex_en, if1.idex_clr, if1.exmem_en, if1.memwb_clr};
  endfunction

  initial begin
    //               rst rs1 rs2 u1 u2 mr rd rdr st  ctrl  inf to  sc  fe
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 0, 0, 0));   // reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0, 0));   // idle
    tbl.push_back(mk(0, 0, 5, 0, 1, 1, 5, 0, 0, E_LU,  0, 0, 0, 0));   // load-use on rs2
    tbl.push_back(mk(0, 0, 5, 0, 1, 0, 5, 0, 0, E_RUN, 0, 0, 1, 0));   // bubble in EX
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, E_RUN, 0, 0, 1, 0));   // rd = x0
    tbl.push_back(mk(0, 0, 5, 0, 0, 1, 5, 0, 0, E_RUN, 0, 0, 1, 0));   // rs2 not used
    tbl.push_back(mk(0, 7, 0, 1, 0, 1, 7, 0, 0, E_LU,  0, 0, 1, 0));   // load-use on rs1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_RDR, 0, 0, 2, 0));   // redirect
    tbl.push_back(mk(0, 0, 5, 0, 1, 1, 5, 0, 0, E_FLS, 1, 0, 2, 1));   // hazard masked in FLUSH
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FLS, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_MEM, 0, 0, 2, 1));   // stall + redirect
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_MEM, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_MEM, 0, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_RDR, 0, 0, 5, 1));   // redirect taken
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_RDR, 1, 0, 5, 2));   // redirect in FLUSH
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FLS, 1, 0, 5, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 1, 0, 5, 3));   // stall holds FLUSH
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_FLS, 1, 0, 6, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 6, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 0, 6, 3));   // 6-cycle stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 0, 7, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 0, 8, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 0, 9, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 1, 10, 3));  // timeout visible
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MEM, 0, 1, 11, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 1, 12, 3));  // sticky
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 1, 12, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 1, 12, 3));  // reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_RDR, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 1, 0, 0, 1));   // reset mid-FLUSH
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0, 0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_OFF, 0, 0, 0, 0));
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("r%0d ctrl", i), 32'(ctrl0()), 32'(tbl[i].ctrl));
      chk($sformatf("r%0d in_flush/timeout", i), 32'({if0.in_flush, if0.mem_timeout}),
          32'({tbl[i].inf, tbl[i].to}));
      chk($sformatf("r%0d stall_cycles", i), if0.stall_cycles, tbl[i].sc);
      chk($sformatf("r%0d flush_events", i), if0.flush_events, tbl[i].fe);
    end

    // FETCH_LAT=3: reset during the first FLUSH cycle
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("fl3 redirect ctrl", 32'(ctrl1()), 32'(E_RDR));
    chk("fl3 redirect in_flush", 32'(if1.in_flush), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("fl3 rst ctrl", 32'(ctrl1()), 32'(E_OFF));
    chk("fl3 rst in_flush", 32'(if1.in_flush), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("fl3 post-rst ctrl", 32'(ctrl1()), 32'(E_RUN));
    chk("fl3 post-rst in_flush", 32'(if1.in_flush), 32'd0);
    chk("fl3 post-rst stall_cycles", if1.stall_cycles, 32'd0);
    chk("fl3 post-rst flush_events", if1.flush_events, 32'd0);
    chk("fl3 post-rst timeout", 32'(if1.mem_timeout), 32'd0);

    // FETCH_LAT=3: full flush window
    step(1'b0, 1'b1, 1'b0);
    chk("fl3 redirect2 ctrl", 32'(ctrl1()), 32'(E_RDR));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("fl3 flush%0d ctrl", k + 1), 32'(ctrl1()), 32'(E_FLS));
      chk($sformatf("fl3 flush%0d in_flush", k + 1), 32'(if1.in_flush), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("fl3 end ctrl", 32'(ctrl1()), 32'(E_RUN));
    chk("fl3 end in_flush", 32'(if1.in_flush), 32'd0);
    chk("fl3 end flush_events", if1.flush_events, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
